aes_key_sched_ctrl: RTL and testbench
=====================================

# aes_key_sched_ctrl

Sequencer for the byte-serial AES-128 key-expansion datapath: it takes a cipher key on a start handshake, steps the datapath's round/cnt inputs through all ten expansion rounds, and captures each 128-bit round key as it appears. It sits between the host key-load interface and the cipher core. When the key store is compiled in, it also holds the 11 round keys the core reads during encryption.

## Interface
- No parameters. Fixed AES-128: 11 round keys, 6 datapath steps per round.
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- start_i  in  1  start request; sampled only in IDLE
- key_i  in  128  cipher key; must be stable during the LOAD cycle
- busy_o  out  1  high whenever the state is not IDLE
- done_o  out  1  one-cycle pulse when the schedule is complete
- key_valid_o  out  1  all 11 keys present in the store
- ke_load_o  out  1  one-cycle pulse: datapath loads key_i into its w-matrix
- ke_key_o  out  128  key_i forwarded to the datapath
- ke_round_o  out  4  round index to the datapath (0..9)
- ke_cnt_o  out  3  step index to the datapath (0..5; 7 = idle)
- ke_key_i  in  128  current round key from the datapath
- rk_wr_en_o  out  1  round-key write strobe
- rk_wr_addr_o  out  4  round-key index (0..10)
- rk_wr_data_o  out  128  round-key data (ke_key_i, copied unchanged)
- rk_rd_addr_i  in  4  key-store read address
- rk_rd_data_o  out  128  key-store read data; registered

## Operation
- FSM states:
  - IDLE: start_i=1 -> LOAD.
  - LOAD: ke_load_o=1 -> WR.
  - WR: write entry `idx`. If idx=10 -> DONE, else -> EXP with cnt=0.
  - EXP: cnt steps 0,1,2,3 (S-box bytes), 4 (Rcon), 5 (write-back). After cnt=5: round+1, idx+1, -> WR.
  - DONE: done_o=1 -> IDLE.
- Output values by state:
  - ke_cnt_o = cnt in EXP, 3'd7 in every other state.
  - ke_round_o = current round (0..9) in EXP, 0 in every other state.
- Write port:
  - rk_wr_en_o=1 only in WR.
  - rk_wr_addr_o=idx.
  - rk_wr_data_o=ke_key_i, written verbatim.
- key_valid_o:
  - Cleared when LOAD is entered.
  - Set when DONE is entered.
  - Holds its value in IDLE.
- Ignored inputs:
  - start_i in any non-IDLE state, including DONE. No queueing.
  - key_i changes after the LOAD cycle.
- Read port:
  - rk_rd_data_o is the entry at rk_rd_addr_i one cycle later.
  - Addresses 11..15 read 0.
  - Read and write to the same address in the same cycle returns the old data.
- Datapath counters (round, cnt, idx) are 4b/3b/4b and saturate by FSM construction; they never wrap.

## Timing
- Reset values:
  - State IDLE.
  - busy_o, done_o, key_valid_o, ke_load_o, rk_wr_en_o = 0.
  - ke_round_o=0, ke_cnt_o=7.
  - rk_wr_addr_o=0, rk_rd_data_o=0.
- Key-store contents are not reset.
- Cycle numbering: start_i is sampled at edge 0.
  - Cycle 1: LOAD.
  - Cycle 2: WR idx0.
  - Round r occupies cycles 3+7r .. 9+7r (EXP cnt 0..5, then WR idx r+1).
  - WR idx10 is cycle 72.
  - DONE is cycle 73, and busy_o falls at edge 73.
- Total latency: 73 cycles from start_i to done_o.
- A new start_i is accepted in the cycle after DONE (earliest at cycle 74).
- rst_n asserted mid-schedule:
  - Immediate return to IDLE; all outputs take their reset values.
  - key_valid_o=0.
  - Partial key-store entries remain but are not flagged valid.

## Configuration
- AES_KS_STORE_EN defined:
  - Internal 11x128 register store, written from the write port.
  - rk_rd_* functional; key_valid_o as specified.
- AES_KS_STORE_EN undefined:
  - No store.
  - rk_rd_data_o tied to 0; key_valid_o tied to 0.
  - The write port is the only key output and the FSM is unchanged.

## Test plan
- FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c:
  - 11 write strobes at cycles 2, 9, …, 72; done_o at cycle 73.
  - Round 1 words = a0fafe17 88542cb1 23a33939 2a6c7605 (packed as the datapath outputs).
  - Round 10 words = d014f9a8 c9ee2589 e13f0cc8 b6630ca6.
- Key 000102…0f, then read addr 10 -> rk_rd_data_o holds 13111d7f e3944a17 f307a78b 4d2b30c5 one cycle later.
- start_i held high through the run and in DONE:
  - Exactly one schedule runs.
  - The next schedule begins at cycle 74.
  - key_valid_o drops at that LOAD.
- rst_n pulsed at cycle 30:
  - All outputs return to reset values; key_valid_o=0.
  - A fresh start then produces correct keys.
- Read addr 11 and 15 -> 0.
- Read addr 3 while addr 3 is being written -> previous contents.
- Build with AES_KS_STORE_EN undefined:
  - Write-port sequence identical to the defined build.
  - rk_rd_data_o=0 and key_valid_o=0 throughout.

Source files
------------

// File: rtl/aes_key_sched_ctrl_if.sv
// aes_key_sched_ctrl_if: bundles the host key-load handshake, the key-expansion
// datapath controls and the round-key write/read ports of aes_key_sched_ctrl.
//
// Signals (directions as seen from the controller, i.e. the slave modport):
//   start_i       in   start request, sampled only while idle
//   key_i         in   128-bit cipher key, stable during the load cycle
//   busy_o        out  schedule in progress
//   done_o        out  one-cycle completion pulse
//   key_valid_o   out  all 11 round keys present in the key store
//   ke_load_o     out  datapath loads key_i into its w-matrix
//   ke_key_o      out  key_i forwarded to the datapath
//   ke_round_o    out  datapath round index (0..9)
//   ke_cnt_o      out  datapath step index (0..5, 7 when not expanding)
//   ke_key_i      in   current round key from the datapath
//   rk_wr_en_o    out  round-key write strobe
//   rk_wr_addr_o  out  round-key index (0..10)
//   rk_wr_data_o  out  round-key data
//   rk_rd_addr_i  in   key-store read address
//   rk_rd_data_o  out  key-store read data, registered
//
// master: host/datapath side (drives the *_i signals).
// slave:  controller side.
interface aes_key_sched_ctrl_if;
    logic         start_i;
    logic [127:0] key_i;
    logic         busy_o;
    logic         done_o;
    logic         key_valid_o;
    logic         ke_load_o;
    logic [127:0] ke_key_o;
    logic [3:0]   ke_round_o;
    logic [2:0]   ke_cnt_o;
    logic [127:0] ke_key_i;
    logic         rk_wr_en_o;
    logic [3:0]   rk_wr_addr_o;
    logic [127:0] rk_wr_data_o;
    logic [3:0]   rk_rd_addr_i;
    logic [127:0] rk_rd_data_o;

    modport master (
        output start_i,
        output key_i,
        output ke_key_i,
        output rk_rd_addr_i,
        input  busy_o,
        input  done_o,
        input  key_valid_o,
        input  ke_load_o,
        input  ke_key_o,
        input  ke_round_o,
        input  ke_cnt_o,
        input  rk_wr_en_o,
        input  rk_wr_addr_o,
        input  rk_wr_data_o,
        input  rk_rd_data_o
    );

    modport slave (
        input  start_i,
        input  key_i,
        input  ke_key_i,
        input  rk_rd_addr_i,
        output busy_o,
        output done_o,
        output key_valid_o,
        output ke_load_o,
        output ke_key_o,
        output ke_round_o,
        output ke_cnt_o,
        output rk_wr_en_o,
        output rk_wr_addr_o,
        output rk_wr_data_o,
        output rk_rd_data_o
    );
endinterface

// File: rtl/aes_key_sched_ctrl.sv
// aes_key_sched_ctrl: sequencer for the byte-serial AES-128 key-expansion
// datapath. A start request loads the cipher key into the datapath, then the
// controller steps round/cnt through ten expansion rounds (six steps each) and
// issues one write strobe per round key (11 in total) as each key appears on
// ke_key_i.
//
// Ports:
//   clk    clock
//   rst_n  asynchronous active-low reset
//   bus    aes_key_sched_ctrl_if.slave (handshake, datapath controls,
//          round-key write and read ports)
//
// Build option AES_KS_STORE_EN:
//   defined   - an internal 11 x 128 register store captures the write port;
//               rk_rd_data_o returns entry rk_rd_addr_i one cycle later
//               (addresses 11..15 read 0), key_valid_o flags a complete set.
//   undefined - no store; rk_rd_data_o and key_valid_o are tied to 0 and the
//               write port is the only key output. The FSM is identical.
module aes_key_sched_ctrl (
    input logic               clk,
    input logic               rst_n,
    aes_key_sched_ctrl_if.slave bus
);

    localparam int unsigned NumKeys = 11;
    localparam logic [3:0]  LastIdx = 4'd10;
    localparam logic [2:0]  LastCnt = 3'd5;
    localparam logic [2:0]  CntIdle = 3'd7;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StWr,
        StExp,
        StDone
    } state_e;

    state_e     state_q, state_d;
    logic [3:0] round_q, round_d;
    logic [2:0] cnt_q, cnt_d;
    logic [3:0] idx_q, idx_d;

    logic       busy;
    logic       done;
    logic       load;
    logic       wr_en;
    logic [3:0] round_out;
    logic [2:0] cnt_out;

    // ------------------------------------------------------------------
    // State and counter registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            round_q <= 4'd0;
            cnt_q   <= 3'd0;
            idx_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            round_q <= round_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and output decode
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        round_d   = round_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        busy      = 1'b1;
        done      = 1'b0;
        load      = 1'b0;
        wr_en     = 1'b0;
        round_out = 4'd0;
        cnt_out   = CntIdle;

        unique case (state_q)
            StIdle: begin
                busy = 1'b0;
                if (bus.start_i) begin
                    state_d = StLoad;
                    round_d = 4'd0;
                    cnt_d   = 3'd0;
                    idx_d   = 4'd0;
                end
            end

            StLoad: begin
                load    = 1'b1;
                state_d = StWr;
            end

            StWr: begin
                wr_en = 1'b1;
                if (idx_q == LastIdx) begin
                    state_d = StDone;
                end else begin
                    state_d = StExp;
                    cnt_d   = 3'd0;
                end
            end

            StExp: begin
                round_out = round_q;
                cnt_out   = cnt_q;
                // Step 5 is the datapath write-back; the new round key is on
                // ke_key_i in the following WR cycle.
                if (cnt_q == LastCnt) begin
                    cnt_d   = 3'd0;
                    round_d = round_q + 4'd1;
                    idx_d   = idx_q + 4'd1;
                    state_d = StWr;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end

            StDone: begin
                done    = 1'b1;
                state_d = StIdle;
                // Park the counters so the write address idles at 0.
                round_d = 4'd0;
                cnt_d   = 3'd0;
                idx_d   = 4'd0;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign bus.busy_o       = busy;
    assign bus.done_o       = done;
    assign bus.ke_load_o    = load;
    assign bus.ke_key_o     = bus.key_i;
    assign bus.ke_round_o   = round_out;
    assign bus.ke_cnt_o     = cnt_out;
    assign bus.rk_wr_en_o   = wr_en;
    assign bus.rk_wr_addr_o = idx_q;
    assign bus.rk_wr_data_o = bus.ke_key_i;

    // ------------------------------------------------------------------
    // Optional round-key store
    // ------------------------------------------------------------------
`ifdef AES_KS_STORE_EN
    logic [127:0] store_q [NumKeys];
    logic [127:0] rd_data_q;
    logic         key_valid_q;
    logic         valid_clr;
    logic         valid_set;

    assign valid_clr = (state_q == StIdle) && bus.start_i;
    assign valid_set = (state_q == StWr) && (idx_q == LastIdx);

    // Contents deliberately not reset; only key_valid says whether they are
    // a complete set.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            store_q[idx_q] <= bus.ke_key_i;
        end
    end

    // Registered read sees the pre-write value on a same-address collision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q <= '0;
        end else if (bus.rk_rd_addr_i < 4'(NumKeys)) begin
            rd_data_q <= store_q[bus.rk_rd_addr_i];
        end else begin
            rd_data_q <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_valid_q <= 1'b0;
        end else if (valid_clr) begin
            key_valid_q <= 1'b0;
        end else if (valid_set) begin
            key_valid_q <= 1'b1;
        end
    end

    assign bus.rk_rd_data_o = rd_data_q;
    assign bus.key_valid_o  = key_valid_q;
`else
    logic unused_rd_addr;

    assign unused_rd_addr   = ^bus.rk_rd_addr_i;
    assign bus.rk_rd_data_o = '0;
    assign bus.key_valid_o  = 1'b0;
`endif

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// Self-checking bench for aes_key_sched_ctrl. A small AES-128 datapath model
// answers the controller's load/step controls; a timeline model (cycle offset
// since the accepted start) plus a golden key expansion predicts every output
// each cycle. Honours AES_KS_STORE_EN for the store-dependent outputs.
module tb_aes_key_sched_ctrl;

`ifdef AES_KS_STORE_EN
    localparam bit StoreEn = 1'b1;
`else
    localparam bit StoreEn = 1'b0;
`endif

    logic clk;
    logic rst_n;

    aes_key_sched_ctrl_if bus ();

    aes_key_sched_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // ---------------- AES arithmetic ----------------
    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] v;
        v = 8'h01;
        for (int i = 0; i < 254; i++) v = gmul(v, a);  // a^254 = a^-1, 0 -> 0
        return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]}
               ^ 8'h63;
    endfunction

    function automatic logic [127:0] next_rk(input logic [127:0] k, input int r);
        logic [31:0] w0, w1, w2, w3, t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < r; i++) rc = xt(rc);
        {w0, w1, w2, w3} = k;
        t  = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])} ^ {rc, 24'h0};
        w0 = w0 ^ t;
        w1 = w1 ^ w0;
        w2 = w2 ^ w1;
        w3 = w3 ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    // ---------------- Datapath model ----------------
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) bus.ke_key_i <= '0;
        else if (bus.ke_load_o) bus.ke_key_i <= bus.key_i;
        else if (bus.ke_cnt_o == 3'd5) bus.ke_key_i <= next_rk(bus.ke_key_i, int'(bus.ke_round_o));
    end

    // ---------------- Reference model ----------------
    // t = 0 idle, otherwise the cycle number within the schedule (1 = LOAD,
    // 2 + 7k = write of key k, 73 = DONE).
    int           t = 0;
    logic [127:0] gold [11];
    logic [127:0] mstore [11];
    bit           mknown [11];
    bit           mvalid = 1'b0;
    logic [127:0] mrd = '0;
    bit           mrd_known = 1'b1;

    always @(posedge clk or negedge rst_n) begin
        int a;
        if (!rst_n) begin
            t         = 0;
            mvalid    = 1'b0;
            mrd       = '0;
            mrd_known = 1'b1;
        end else begin
            a = int'(bus.rk_rd_addr_i);
            if (!StoreEn || a > 10) begin
                mrd       = '0;
                mrd_known = 1'b1;
            end else begin
                mrd       = mstore[a];
                mrd_known = mknown[a];
            end
            if (t >= 2 && t <= 72 && (t - 2) % 7 == 0) begin
                mstore[(t - 2) / 7] = gold[(t - 2) / 7];
                mknown[(t - 2) / 7] = 1'b1;
            end
            if (t == 1) begin
                gold[0] = bus.key_i;
                for (int i = 1; i < 11; i++) gold[i] = next_rk(gold[i - 1], i - 1);
            end
            if (t == 0) begin
                if (bus.start_i) begin
                    t      = 1;
                    mvalid = 1'b0;
                end
            end else if (t == 73) begin
                t = 0;
            end else begin
                t++;
                if (t == 73) mvalid = 1'b1;
            end
        end
    end

    // ---------------- Compare process ----------------
    logic [127:0] obs_wr [11];
    int           wr_seen = 0;

    always @(negedge clk) begin
        bit wr;
        int er, ec, idx;
        wr  = (t >= 2 && t <= 72 && (t - 2) % 7 == 0);
        idx = (t - 2) / 7;
        er  = 0;
        ec  = 7;
        if (t >= 3 && t <= 71 && !wr) begin
            er = (t - 3) / 7;
            ec = (t - 3) % 7;
        end
        chk("busy", bus.busy_o, t != 0);
        chk("done", bus.done_o, t == 73);
        chk("ke_load", bus.ke_load_o, t == 1);
        chk("ke_key", bus.ke_key_o, bus.key_i);
        chk("ke_round", bus.ke_round_o, er);
        chk("ke_cnt", bus.ke_cnt_o, ec);
        chk("wr_en", bus.rk_wr_en_o, wr);
        chk("key_valid", bus.key_valid_o, StoreEn ? mvalid : 1'b0);
        if (wr) begin
            chk("wr_addr", bus.rk_wr_addr_o, idx);
            chk("wr_data", bus.rk_wr_data_o, gold[idx]);
            obs_wr[idx] = bus.rk_wr_data_o;
            wr_seen++;
        end
        if (mrd_known) chk("rd_data", bus.rk_rd_data_o, mrd);
    end

    // ---------------- Stimulus ----------------
    // Called in an idle cycle; returns in the idle cycle after DONE.
    task automatic run_sched(input logic [127:0] key, input bit hold, input bit coll,
                             output int done_n);
        logic [127:0] prev3;
        bit           prev3_known;
        prev3       = '0;
        prev3_known = 1'b0;
        wr_seen     = 0;
        bus.start_i = 1'b1;
        bus.key_i   = key;
        done_n      = -1;
        for (int n = 1; n <= 200; n++) begin
            @(posedge clk);
            #1;
            if (n >= 2) bus.key_i = {$urandom, $urandom, $urandom, $urandom};
            if (coll && n == 24 && prev3_known)
                chk("rd_wr_collision", bus.rk_rd_data_o, StoreEn ? prev3 : 128'h0);
            if (coll && n == 23) begin
                prev3             = mstore[3];
                prev3_known       = mknown[3];
                bus.rk_rd_addr_i  = 4'd3;
            end else begin
                bus.rk_rd_addr_i = 4'($urandom_range(0, 15));
            end
            if (bus.done_o) done_n = n;
            bus.start_i = hold ? 1'b1 : (done_n < 0 ? 1'($urandom_range(0, 1)) : 1'b0);
            if (done_n >= 0) break;
        end
        if (done_n < 0) chk("timeout_done", bus.done_o, 1'b1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int done_n;
        rst_n            = 1'b0;
        bus.start_i      = 1'b0;
        bus.key_i        = '0;
        bus.rk_rd_addr_i = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", bus.busy_o, 1'b0);
        chk("rst_cnt", bus.ke_cnt_o, 3'd7);
        chk("rst_wr_addr", bus.rk_wr_addr_o, 4'd0);
        chk("rst_rd_data", bus.rk_rd_data_o, 128'h0);
        chk("rst_valid", bus.key_valid_o, 1'b0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // FIPS-197 example key
        run_sched(128'h2b7e151628aed2a6abf7158809cf4f3c, 1'b0, 1'b1, done_n);
        chk("fips_latency", done_n, 73);
        chk("fips_writes", wr_seen, 11);
        chk("fips_rk0", obs_wr[0], 128'h2b7e151628aed2a6abf7158809cf4f3c);
        chk("fips_rk1", obs_wr[1], 128'ha0fafe1788542cb123a339392a6c7605);
        chk("fips_rk10", obs_wr[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        chk("fips_valid", bus.key_valid_o, StoreEn);

        // Reset in the middle of a schedule
        bus.start_i = 1'b1;
        bus.key_i   = {$urandom, $urandom, $urandom, $urandom};
        repeat (30) begin
            @(posedge clk);
            #1;
            bus.start_i = 1'b0;
        end
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", bus.busy_o, 1'b0);
        chk("midrst_valid", bus.key_valid_o, 1'b0);
        chk("midrst_cnt", bus.ke_cnt_o, 3'd7);
        chk("midrst_wr_en", bus.rk_wr_en_o, 1'b0);
        chk("midrst_rd", bus.rk_rd_data_o, 128'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Fresh schedule, then directed reads
        run_sched(128'h000102030405060708090a0b0c0d0e0f, 1'b0, 1'b1, done_n);
        chk("seq_latency", done_n, 73);
        chk("seq_rk10", obs_wr[10], 128'h13111d7fe3944a17f307a78b4d2b30c5);
        bus.rk_rd_addr_i = 4'd10;
        @(posedge clk);
        #1;
        chk("rd_addr10", bus.rk_rd_data_o,
            StoreEn ? 128'h13111d7fe3944a17f307a78b4d2b30c5 : 128'h0);
        bus.rk_rd_addr_i = 4'd11;
        @(posedge clk);
        #1;
        chk("rd_addr11", bus.rk_rd_data_o, 128'h0);
        bus.rk_rd_addr_i = 4'd15;
        @(posedge clk);
        #1;
        chk("rd_addr15", bus.rk_rd_data_o, 128'h0);

        // Random keys
        for (int k = 0; k < 3; k++) begin
            run_sched({$urandom, $urandom, $urandom, $urandom}, 1'b0, 1'b1, done_n);
            chk("rand_latency", done_n, 73);
            chk("rand_writes", wr_seen, 11);
        end

        // start_i held high through the run and DONE
        run_sched({$urandom, $urandom, $urandom, $urandom}, 1'b1, 1'b1, done_n);
        chk("hold_latency", done_n, 73);
        chk("hold_writes", wr_seen, 11);
        chk("hold_idle74", bus.busy_o, 1'b0);
        chk("hold_valid74", bus.key_valid_o, StoreEn);
        @(posedge clk);
        #1;
        chk("hold_load75", bus.ke_load_o, 1'b1);
        chk("hold_valid_drop", bus.key_valid_o, 1'b0);
        bus.start_i = 1'b0;
        done_n = -1;
        for (int n = 1; n <= 200; n++) begin
            @(posedge clk);
            #1;
            bus.key_i        = {$urandom, $urandom, $urandom, $urandom};
            bus.rk_rd_addr_i = 4'($urandom_range(0, 15));
            if (bus.done_o) begin
                done_n = n;
                break;
            end
        end
        chk("hold_second_done", done_n, 72);
        repeat (3) @(posedge clk);
        #1;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
